// File: rtl/d_e_pipe_reg_pkg.sv
// Shared definitions for the Decode/Execute pipeline register of the 5-stage MIPS core.
// Optional feature macro used by the consumers of this package: DE_EXC_EN.
package d_e_pipe_reg_pkg;

    // Default datapath / hazard-field geometry.
    localparam int          DE_DW     = 32;
    localparam int          DE_TW     = 2;
    localparam logic [31:0] DE_PC_RST = 32'h0000_3000;

    // ALU operation encodings carried on ALU_Ctr.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_OR  = 4'd2,
        ALU_LUI = 4'd3
    } alu_op_e;

    // Write-back source select encodings carried on WDSel.
    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_DM  = 2'd1,
        WD_PC8 = 2'd2
    } wdsel_e;

    // CP0 exception codes that can travel down the pipe.
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/d_e_pipe_reg.sv
// Decode-to-Execute pipeline register.
// Captures decoded operands, ALU control, write-back destination and Tnew at the
// D/E boundary, supports hold (en=0) and bubble insertion (flush=1), and counts
// Tnew down by one (saturating at 0) as an instruction moves from D into E.
// Optional macro DE_EXC_EN adds ExcCode/BD tracking; bubbles then keep the D-stage
// PC and BD so CP0 can still report a correct EPC.
module d_e_pipe_reg
    import d_e_pipe_reg_pkg::*;
#(
    parameter int          DW     = DE_DW,
    parameter logic [31:0] PC_RST = DE_PC_RST,
    parameter int          TW     = DE_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic [DW-1:0] PC_D,
    input  logic [DW-1:0] RD1_D,
    input  logic [DW-1:0] RD2_D,
    input  logic [DW-1:0] Ext_D,
    input  logic [4:0]    Shamt_D,
    input  logic [3:0]    ALU_Ctr_D,
    input  logic          ALUSrcB_D,
    input  logic [4:0]    A1_D,
    input  logic [4:0]    A2_D,
    input  logic [4:0]    A3_D,
    input  logic          RegWrite_D,
    input  logic [1:0]    WDSel_D,
    input  logic          MemWrite_D,
    input  logic [TW-1:0] Tnew_D,
    output logic [DW-1:0] PC_E,
    output logic [DW-1:0] RD2_E,
    output logic [DW-1:0] Ext_E,
    output logic [DW-1:0] SrcA_E,
    output logic [DW-1:0] SrcB_E,
    output logic [4:0]    Shamt_E,
    output logic [3:0]    ALU_Ctr_E,
    output logic [4:0]    A1_E,
    output logic [4:0]    A2_E,
    output logic [4:0]    A3_E,
    output logic          RegWrite_E,
    output logic          MemWrite_E,
    output logic [1:0]    WDSel_E,
    output logic [TW-1:0] Tnew_E,
    output logic          Valid_E
`ifdef DE_EXC_EN
    ,
    input  logic [4:0]    ExcCode_D,
    input  logic          BD_D,
    output logic [4:0]    ExcCode_E,
    output logic          BD_E
`endif
);

    // Everything held across the D/E boundary, as one record.
    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] ext;
        logic          alusrcb;
        logic [4:0]    shamt;
        logic [3:0]    alu_ctr;
        logic [4:0]    a1;
        logic [4:0]    a2;
        logic [4:0]    a3;
        logic          regwrite;
        logic          memwrite;
        logic [1:0]    wdsel;
        logic [TW-1:0] tnew;
        logic          valid;
`ifdef DE_EXC_EN
        logic [4:0]    exccode;
        logic          bd;
`endif
    } de_t;

    de_t de_q;
    de_t de_d;

    // Tnew is counted from D; one stage later it is one smaller, never below 0.
    function automatic logic [TW-1:0] tnew_sat_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : (t - TW'(1));
    endfunction

    // Register contents after reset: all clear except the boot PC.
    function automatic de_t reset_value();
        de_t r;
        r    = '0;
        r.pc = PC_RST[DW-1:0];
        return r;
    endfunction

    // A NOP bubble: no write-back, no store, no hazard, not a valid instruction.
    function automatic de_t bubble_value();
        de_t b;
        b = '0;
`ifdef DE_EXC_EN
        // EPC of a squashed slot must still point at the instruction in D.
        b.pc = PC_D;
        b.bd = BD_D;
`else
        b.pc = PC_RST[DW-1:0];
`endif
        return b;
    endfunction

    // Fresh instruction coming in from D.
    function automatic de_t load_value();
        de_t l;
        l.pc       = PC_D;
        l.rd1      = RD1_D;
        l.rd2      = RD2_D;
        l.ext      = Ext_D;
        l.alusrcb  = ALUSrcB_D;
        l.shamt    = Shamt_D;
        l.alu_ctr  = ALU_Ctr_D;
        l.a1       = A1_D;
        l.a2       = A2_D;
        // Register 0 is kept as given; the hazard unit filters it out.
        l.a3       = A3_D;
        l.regwrite = RegWrite_D;
        l.memwrite = MemWrite_D;
        l.wdsel    = WDSel_D;
        l.tnew     = tnew_sat_dec(Tnew_D);
        l.valid    = 1'b1;
`ifdef DE_EXC_EN
        l.exccode  = ExcCode_D;
        l.bd       = BD_D;
`endif
        return l;
    endfunction

    // Next-state select: flush beats hold, hold beats load.
    always_comb begin
        de_d = de_q;
        if (flush) begin
            de_d = bubble_value();
        end else if (en) begin
            de_d = load_value();
        end
    end

    // D/E boundary: state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q <= reset_value();
        end else begin
            de_q <= de_d;
        end
    end

    // Registered outputs, plus the single combinational SrcB operand mux.
    always_comb begin
        PC_E       = de_q.pc;
        SrcA_E     = de_q.rd1;
        RD2_E      = de_q.rd2;
        Ext_E      = de_q.ext;
        SrcB_E     = de_q.alusrcb ? de_q.ext : de_q.rd2;
        Shamt_E    = de_q.shamt;
        ALU_Ctr_E  = de_q.alu_ctr;
        A1_E       = de_q.a1;
        A2_E       = de_q.a2;
        A3_E       = de_q.a3;
        RegWrite_E = de_q.regwrite;
        MemWrite_E = de_q.memwrite;
        WDSel_E    = de_q.wdsel;
        Tnew_E     = de_q.tnew;
        Valid_E    = de_q.valid;
`ifdef DE_EXC_EN
        ExcCode_E  = de_q.exccode;
        BD_E       = de_q.bd;
`endif
    end

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Self-checking bench for d_e_pipe_reg: directed steps plus randomized traffic,
// compared against a field-level reference model. Honours DE_EXC_EN if defined.
module tb_d_e_pipe_reg;

    localparam logic [31:0] PCR = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, en, flush;
    logic [31:0] PC_D, RD1_D, RD2_D, Ext_D;
    logic [4:0]  Shamt_D, A1_D, A2_D, A3_D;
    logic [3:0]  ALU_Ctr_D;
    logic        ALUSrcB_D, RegWrite_D, MemWrite_D;
    logic [1:0]  WDSel_D;
    logic [1:0]  Tnew_D;
    logic [31:0] PC_E, RD2_E, Ext_E, SrcA_E, SrcB_E;
    logic [4:0]  Shamt_E, A1_E, A2_E, A3_E;
    logic [3:0]  ALU_Ctr_E;
    logic        RegWrite_E, MemWrite_E, Valid_E;
    logic [1:0]  WDSel_E;
    logic [1:0]  Tnew_E;
`ifdef DE_EXC_EN
    logic [4:0]  ExcCode_D, ExcCode_E;
    logic        BD_D, BD_E;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state (what E should be showing).
    logic [31:0] m_pc, m_rd1, m_rd2, m_ext;
    logic        m_bsel, m_rw, m_mw, m_valid;
    logic [4:0]  m_shamt, m_a1, m_a2, m_a3, m_exc;
    logic [3:0]  m_alu;
    logic [1:0]  m_wd;
    int          m_tnew;
    logic        m_bd;

    d_e_pipe_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .PC_D(PC_D), .RD1_D(RD1_D), .RD2_D(RD2_D), .Ext_D(Ext_D),
        .Shamt_D(Shamt_D), .ALU_Ctr_D(ALU_Ctr_D), .ALUSrcB_D(ALUSrcB_D),
        .A1_D(A1_D), .A2_D(A2_D), .A3_D(A3_D), .RegWrite_D(RegWrite_D),
        .WDSel_D(WDSel_D), .MemWrite_D(MemWrite_D), .Tnew_D(Tnew_D),
        .PC_E(PC_E), .RD2_E(RD2_E), .Ext_E(Ext_E), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E),
        .Shamt_E(Shamt_E), .ALU_Ctr_E(ALU_Ctr_E), .A1_E(A1_E), .A2_E(A2_E),
        .A3_E(A3_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
        .WDSel_E(WDSel_E), .Tnew_E(Tnew_E), .Valid_E(Valid_E)
`ifdef DE_EXC_EN
        , .ExcCode_D(ExcCode_D), .BD_D(BD_D), .ExcCode_E(ExcCode_E), .BD_E(BD_E)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = PCR; m_rd1 = 0; m_rd2 = 0; m_ext = 0; m_bsel = 0;
        m_shamt = 0; m_alu = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0;
        m_rw = 0; m_mw = 0; m_wd = 0; m_tnew = 0; m_valid = 0;
        m_exc = 0; m_bd = 0;
    endtask

    // Apply the update rules for one rising edge using the current D inputs.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (flush) begin
            model_reset();
`ifdef DE_EXC_EN
            m_pc = PC_D;
            m_bd = BD_D;
`endif
        end else if (en) begin
            m_pc = PC_D; m_rd1 = RD1_D; m_rd2 = RD2_D; m_ext = Ext_D; m_bsel = ALUSrcB_D;
            m_shamt = Shamt_D; m_alu = ALU_Ctr_D; m_a1 = A1_D; m_a2 = A2_D; m_a3 = A3_D;
            m_rw = RegWrite_D; m_mw = MemWrite_D; m_wd = WDSel_D;
            m_tnew = (int'(Tnew_D) > 0) ? int'(Tnew_D) - 1 : 0;
            m_valid = 1'b1;
`ifdef DE_EXC_EN
            m_exc = ExcCode_D;
            m_bd  = BD_D;
`endif
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".PC_E"}, PC_E, m_pc);
        chk({ctx, ".SrcA_E"}, SrcA_E, m_rd1);
        chk({ctx, ".RD2_E"}, RD2_E, m_rd2);
        chk({ctx, ".Ext_E"}, Ext_E, m_ext);
        chk({ctx, ".SrcB_E"}, SrcB_E, m_bsel ? m_ext : m_rd2);
        chk({ctx, ".Shamt_E"}, 32'(Shamt_E), 32'(m_shamt));
        chk({ctx, ".ALU_Ctr_E"}, 32'(ALU_Ctr_E), 32'(m_alu));
        chk({ctx, ".A1_E"}, 32'(A1_E), 32'(m_a1));
        chk({ctx, ".A2_E"}, 32'(A2_E), 32'(m_a2));
        chk({ctx, ".A3_E"}, 32'(A3_E), 32'(m_a3));
        chk({ctx, ".RegWrite_E"}, 32'(RegWrite_E), 32'(m_rw));
        chk({ctx, ".MemWrite_E"}, 32'(MemWrite_E), 32'(m_mw));
        chk({ctx, ".WDSel_E"}, 32'(WDSel_E), 32'(m_wd));
        chk({ctx, ".Tnew_E"}, 32'(Tnew_E), 32'(m_tnew));
        chk({ctx, ".Valid_E"}, 32'(Valid_E), 32'(m_valid));
`ifdef DE_EXC_EN
        chk({ctx, ".ExcCode_E"}, 32'(ExcCode_E), 32'(m_exc));
        chk({ctx, ".BD_E"}, 32'(BD_E), 32'(m_bd));
`endif
    endtask

    task automatic rand_inputs();
        PC_D = $urandom; RD1_D = $urandom; RD2_D = $urandom; Ext_D = $urandom;
        Shamt_D = 5'($urandom); ALU_Ctr_D = 4'($urandom_range(0, 3));
        ALUSrcB_D = 1'($urandom); A1_D = 5'($urandom); A2_D = 5'($urandom);
        A3_D = 5'($urandom); RegWrite_D = 1'($urandom); MemWrite_D = 1'($urandom);
        WDSel_D = 2'($urandom_range(0, 2)); Tnew_D = 2'($urandom);
`ifdef DE_EXC_EN
        ExcCode_D = 5'($urandom); BD_D = 1'($urandom);
`endif
    endtask

    // One clock: model and DUT see the same inputs at the edge, checked 1 unit later.
    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset asserted from time 0 with live data on RD1_D.
        reset = 1'b1; en = 1'b1; flush = 1'b0;
        rand_inputs();
        RD1_D = 32'h1234;
        model_reset();
        #2;
        check_all("reset_async");
        chk("reset_pc", PC_E, 32'h3000);
        step("reset_held");
        step("reset_held2");

        // Release away from the edge; first load happens on the next edge.
        @(negedge clk);
        reset = 1'b0;
        rand_inputs();
        RD1_D = 32'd5; Ext_D = 32'd7; ALUSrcB_D = 1'b1; ALU_Ctr_D = 4'd1; Tnew_D = 2'd2;
        en = 1'b1; flush = 1'b0;
        step("load");
        chk("load_srca", SrcA_E, 32'd5);
        chk("load_srcb", SrcB_E, 32'd7);
        chk("load_tnew", 32'(Tnew_E), 32'd1);
        chk("load_valid", 32'(Valid_E), 32'd1);

        // Tnew saturation and the other decrement cases.
        rand_inputs(); Tnew_D = 2'd0;
        step("tnew0");
        chk("tnew0_nowrap", 32'(Tnew_E), 32'd0);
        rand_inputs(); Tnew_D = 2'd3;
        step("tnew3");
        rand_inputs(); Tnew_D = 2'd1; ALUSrcB_D = 1'b0;
        step("tnew1");

        // Hold for 3 cycles while D keeps changing.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step("hold");
        end

        // Flush wins over hold.
        rand_inputs(); RegWrite_D = 1'b1; A3_D = 5'd8; en = 1'b0; flush = 1'b1;
        step("flush_hold");
        chk("flush_rw", 32'(RegWrite_E), 32'd0);
        chk("flush_a3", 32'(A3_E), 32'd0);

        // Register 0 destination with RegWrite is captured unchanged.
        rand_inputs(); A3_D = 5'd0; RegWrite_D = 1'b1; en = 1'b1; flush = 1'b0;
        step("a3_zero");

        // Randomized traffic mixing load, hold and flush.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            en    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        // Asynchronous reset mid-cycle, released before the next edge.
        en = 1'b1; flush = 1'b0; rand_inputs();
        step("pre_reset");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_mid");
        #1;
        reset = 1'b0;
        #1;
        check_all("reset_released");
        step("after_reset");

`ifdef DE_EXC_EN
        rand_inputs(); PC_D = 32'h3010; BD_D = 1'b1; ExcCode_D = 5'd4; flush = 1'b1;
        step("exc_flush");
        chk("exc_pc", PC_E, 32'h3010);
        chk("exc_bd", 32'(BD_E), 32'd1);
        chk("exc_code", 32'(ExcCode_E), 32'd0);
        flush = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_e_pipe_reg.md
Name: d_e_pipe_reg

Overview:
- Decode-to-Execute pipeline register of the 5-stage MIPS core.
- Captures decoded operands, ALU control, write-back destination and hazard timing (Tnew) at the D/E boundary.
- Drives the E-stage ALU inputs (SrcA, SrcB, Shamt, ALU_Ctr) and the E-stage hazard/forwarding signals.
- Implements hold (stall of E), bubble insertion (flush), and Tnew countdown between stages.

Parameters:
- DW, 32: datapath width for PC, register data and immediate.
- PC_RST, 32'h0000_3000: PC value loaded on reset and kept in bubbles when DE_EXC_EN is off.
- TW, 2: width of the Tnew field.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  1 = load the D-stage values, 0 = hold current contents
- flush  in  1  1 = load a bubble (NOP) this edge
- PC_D  in  DW  D-stage PC
- RD1_D  in  DW  forwarded rs data from D
- RD2_D  in  DW  forwarded rt data from D
- Ext_D  in  DW  extended immediate
- Shamt_D  in  5  shift amount
- ALU_Ctr_D  in  4  ALU op: 0 add, 1 sub, 2 or, 3 lui
- ALUSrcB_D  in  1  0 = SrcB from RD2, 1 = SrcB from Ext
- A1_D, A2_D  in  5 each  rs/rt register numbers, used by E forwarding
- A3_D  in  5  destination register number
- RegWrite_D  in  1  instruction writes the register file
- WDSel_D  in  2  write-back source select
- MemWrite_D  in  1  store enable
- Tnew_D  in  TW  cycles until result is ready, counted from D
- PC_E, RD2_E, Ext_E  out  DW  registered copies
- SrcA_E  out  DW  registered RD1
- SrcB_E  out  DW  combinational select: ALUSrcB_E ? Ext_E : RD2_E
- Shamt_E  out  5
- ALU_Ctr_E  out  4
- A1_E, A2_E, A3_E  out  5 each
- RegWrite_E, MemWrite_E  out  1 each
- WDSel_E  out  2
- Tnew_E  out  TW
- Valid_E  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset is asynchronous and active-high; it takes effect immediately regardless of clk.
  - Every registered output goes to 0, except PC_E, which goes to PC_RST.
  - Valid_E = 0.
  - SrcB_E then reads 0.
- Update priority at each posedge: reset > flush > hold (en=0) > load.
- Load (en=1, flush=0): every field takes its D value on the edge; Valid_E = 1.
  - Latency is exactly 1 cycle.
- Tnew on load: Tnew_E = (Tnew_D == 0) ? 0 : Tnew_D - 1.
  - Saturating; it never wraps to 3.
- Hold (en=0, flush=0): all fields, including Tnew_E and Valid_E, keep their values.
  - A held instruction does not decrement its Tnew.
- Bubble (flush=1, whatever en is):
  - Cleared to 0: ALU_Ctr, Shamt, A1, A2, A3, RegWrite, MemWrite, WDSel, Tnew, data fields and Valid_E.
  - PC_E = PC_RST (overridden when DE_EXC_EN is on).
  - flush=1 with en=0 still inserts the bubble: flush wins.
- A3_D == 0 with RegWrite_D = 1: captured as given; the hazard unit ignores register 0.
- Reset released mid-cycle: the register stays at reset values until the next posedge.
- No combinational path from any D input to any E output. The only combinational logic is the SrcB_E mux.

Optional Feature:
- Macro DE_EXC_EN.
- When defined, extra ports are added:
  - ExcCode_D in 5 / ExcCode_E out 5
  - BD_D in 1 / BD_E out 1 (branch-delay flag)
- With DE_EXC_EN, ExcCode and BD follow the same load/hold rules as other fields.
- With DE_EXC_EN, a bubble:
  - keeps PC_E = PC_D and BD_E = BD_D, so that CP0 reports a correct EPC for a bubble;
  - clears ExcCode_E to 0.
- With DE_EXC_EN, reset drives ExcCode_E = 0 and BD_E = 0.
- Without DE_EXC_EN, the extra ports do not exist and a bubble's PC_E = PC_RST.

Decomposition:
- Shared package/header:
  - ALU op constants: ALU_ADD=0, ALU_SUB=1, ALU_OR=2, ALU_LUI=3.
  - WDSel encodings: 0 ALU, 1 DM, 2 PC+8.
  - TW and PC_RST.
  - ExcCode constants.
- No sub-module; a single flat module is natural.

Test Plan:
- Reset held with RD1_D=32'h1234 driving -> all outputs 0, PC_E=32'h3000, Valid_E=0.
- Load (en=1): RD1_D=5, Ext_D=7, ALUSrcB_D=1, ALU_Ctr_D=1, Tnew_D=2 -> next cycle SrcA_E=5, SrcB_E=7, ALU_Ctr_E=1, Tnew_E=1, Valid_E=1.
- Tnew_D=0 loaded -> Tnew_E=0, no wrap to 3.
- en=0 for 3 cycles while D inputs change -> E outputs frozen at the prior values, Tnew_E unchanged.
- flush=1 and en=0 together, with RegWrite_D=1, A3_D=8 -> RegWrite_E=0, A3_E=0, Valid_E=0.
- DE_EXC_EN on: flush with PC_D=32'h3010, BD_D=1, ExcCode_D=4 -> PC_E=32'h3010, BD_E=1, ExcCode_E=0.
